// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/reset sequencer of the single-cycle core.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RUN,
    DONE,
    TIMEOUT
  } run_state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_CNT_W = 32;

  // Bit positions when the status flags are mapped into a CSR word
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;

endpackage

// File: rtl/run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at its all-ones value.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run/reset sequencer for the single-cycle core: reset hold, enable gating, halt and timeout.
// Optional macro RUN_CTRL_SELFLOOP_EN adds self-loop (jal x0,0) halt detection.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int          XLEN            = DEF_XLEN,
  parameter int          CNT_W           = DEF_CNT_W,
  parameter int          RST_CYCLES      = 4,
  parameter int unsigned MAX_CYCLES      = 10000,
  parameter int          SELFLOOP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             halt_req_i,
  input  logic [XLEN-1:0]  pc_i,
  output logic             core_rst_o,
  output logic             core_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [XLEN-1:0]  exit_pc_o
);

  localparam logic [7:0]       HOLD_INIT = 8'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(MAX_CYCLES - 1);

  if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
    $error("run_controller: RST_CYCLES must be within 1..255");
  end
  if (CNT_W < 32 && (MAX_CYCLES >> CNT_W) != 0) begin : g_bad_max_cycles
    $error("run_controller: MAX_CYCLES does not fit in CNT_W bits");
  end
  if (SELFLOOP_CYCLES < 2) begin : g_bad_selfloop
    $error("run_controller: SELFLOOP_CYCLES must be at least 2");
  end

  run_state_e state, next_state;
  logic [7:0] hold;
  logic       in_run;
  logic       restart;
  logic       limit_hit;
  logic       selfloop_hit;

  assign in_run = (state == RUN);

  // The post-increment count equals LIMIT exactly when the current count is LIMIT-1
  assign limit_hit = in_run && (LIMIT != '0) && (cycle_cnt_o == LIMIT_M1);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (in_run),
    .clr   (restart),
    .count (cycle_cnt_o)
  );

`ifdef RUN_CTRL_SELFLOOP_EN
  localparam int                 STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(SELFLOOP_CYCLES - 2);

  logic [XLEN-1:0]    last_pc;
  logic [STALL_W-1:0] stall;
  logic               pc_same;

  // The first RUN cycle has no previous PC, so it never counts as a repeat
  assign pc_same      = in_run && (pc_i == last_pc) && (cycle_cnt_o != '0);
  assign selfloop_hit = pc_same && (stall == STALL_PRE);

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (pc_same),
    .clr   (restart || (in_run && !pc_same)),
    .count (stall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_pc <= '0;
    end else if (in_run) begin
      last_pc <= pc_i;
    end
  end
`else
  assign selfloop_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    case (state)
      IDLE, DONE, TIMEOUT: begin
        if (start_i) begin
          next_state = RST_HOLD;
          restart    = 1'b1;
        end
      end
      RST_HOLD: begin
        if (hold == '0) next_state = RUN;
      end
      RUN: begin
        if (halt_req_i || selfloop_hit) next_state = DONE;
        else if (limit_hit)             next_state = TIMEOUT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Core controls are decoded from next_state so they line up with the registered state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
      exit_pc_o  <= '0;
      core_rst_o <= 1'b1;
      core_en_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= next_state;
      core_rst_o <= (next_state == IDLE) || (next_state == RST_HOLD);
      core_en_o  <= (next_state == RUN);
      busy_o     <= (next_state == RST_HOLD) || (next_state == RUN);
      if (restart) begin
        hold      <= HOLD_INIT;
        done_o    <= 1'b0;
        timeout_o <= 1'b0;
        exit_pc_o <= '0;
      end else begin
        if (state == RST_HOLD && hold != '0) hold <= hold - 1'b1;
        if (in_run && next_state == DONE) begin
          done_o    <= 1'b1;
          exit_pc_o <= pc_i;
        end
        if (in_run && next_state == TIMEOUT) begin
          timeout_o <= 1'b1;
          exit_pc_o <= pc_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller against a run-level reference model.
module tb_run_controller;

  localparam int          XLEN            = 32;
  localparam int          CNT_W           = 32;
  localparam int          RST_CYCLES      = 4;
  localparam int unsigned MAX_CYCLES      = 50;
  localparam int          SELFLOOP_CYCLES = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start_i = 1'b0;
  logic             halt_req_i = 1'b0;
  logic [XLEN-1:0]  pc_i = '0;
  logic             core_rst_o;
  logic             core_en_o;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [XLEN-1:0]  exit_pc_o;

  int tests_run = 0;
  int failures  = 0;

  run_controller #(
    .XLEN            (XLEN),
    .CNT_W           (CNT_W),
    .RST_CYCLES      (RST_CYCLES),
    .MAX_CYCLES      (MAX_CYCLES),
    .SELFLOOP_CYCLES (SELFLOOP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .halt_req_i  (halt_req_i),
    .pc_i        (pc_i),
    .core_rst_o  (core_rst_o),
    .core_en_o   (core_en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .cycle_cnt_o (cycle_cnt_o),
    .exit_pc_o   (exit_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input bit rst, input bit en, input bit busy);
    check_output({tag, ".core_rst"}, 64'(core_rst_o), 64'(rst));
    check_output({tag, ".core_en"},  64'(core_en_o),  64'(en));
    check_output({tag, ".busy"},     64'(busy_o),     64'(busy));
  endtask

  task automatic check_status(input string tag, input bit done, input bit tmo,
                              input logic [63:0] cnt, input logic [63:0] pc);
    check_output({tag, ".done"},    64'(done_o),      64'(done));
    check_output({tag, ".timeout"}, 64'(timeout_o),   64'(tmo));
    check_output({tag, ".cnt"},     64'(cycle_cnt_o), cnt);
    check_output({tag, ".exit_pc"}, 64'(exit_pc_o),   pc);
  endtask

  // One complete run. halt_at: RUN cycle raising halt_req (0 = never).
  // loop_from: RUN cycle from which pc is frozen at 0x100 (0 = never).
  // abort_at: RUN cycle during which reset is asserted (0 = never).
  // halt_pc: pc forced on the halt cycle when nonzero.
  task automatic do_run(input int halt_at, input int loop_from, input int abort_at,
                        input logic [XLEN-1:0] halt_pc);
    int              end_k;
    bit              ends_done;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] exp_pc;
    int              gap;

    end_k     = int'(MAX_CYCLES);
    ends_done = 1'b0;
`ifdef RUN_CTRL_SELFLOOP_EN
    if (loop_from > 1 && loop_from + SELFLOOP_CYCLES - 1 <= end_k) begin
      end_k     = loop_from + SELFLOOP_CYCLES - 1;
      ends_done = 1'b1;
    end
`endif
    if (halt_at >= 1 && halt_at <= end_k) begin
      end_k     = halt_at;
      ends_done = 1'b1;
    end
    exp_pc = '0;
    pc     = 32'h0001_0000 + 32'($urandom_range(0, 255) << 2);

    start_i = 1'b1;
    tick();
    for (int i = 1; i <= RST_CYCLES; i++) begin
      check_ctrl($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b1);
      check_status($sformatf("hold%0d", i), 1'b0, 1'b0, 0, 0);
      start_i = ($urandom_range(0, 7) == 0);
      tick();
    end

    for (int k = 1; k <= end_k; k++) begin
      check_ctrl($sformatf("run%0d", k), 1'b0, 1'b1, 1'b1);
      check_status($sformatf("run%0d", k), 1'b0, 1'b0, 64'(k - 1), 0);
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1;
        check_ctrl("abort", 1'b1, 1'b0, 1'b0);
        check_status("abort", 1'b0, 1'b0, 0, 0);
        start_i    = 1'b0;
        halt_req_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check_ctrl("abort_idle", 1'b1, 1'b0, 1'b0);
        check_status("abort_idle", 1'b0, 1'b0, 0, 0);
        return;
      end
      if (loop_from > 0 && k >= loop_from) pc = 32'h0000_0100;
      else                                 pc = pc + 32'(4 * $urandom_range(1, 8));
      if (k == halt_at && halt_pc != '0)    pc = halt_pc;
      pc_i       = pc;
      halt_req_i = (k == halt_at);
      start_i    = ($urandom_range(0, 7) == 0);
      if (k == end_k) exp_pc = pc;
      tick();
    end
    halt_req_i = 1'b0;
    start_i    = 1'b0;

    gap = $urandom_range(1, 3);
    for (int g = 0; g <= gap; g++) begin
      check_ctrl($sformatf("end%0d", g), 1'b0, 1'b0, 1'b0);
      check_status($sformatf("end%0d", g), ends_done, !ends_done, 64'(end_k), 64'(exp_pc));
      pc_i       = 32'($urandom);
      halt_req_i = ($urandom_range(0, 1) == 1);
      tick();
    end
    halt_req_i = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check_ctrl("reset", 1'b1, 1'b0, 1'b0);
    check_status("reset", 1'b0, 1'b0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_ctrl("idle", 1'b1, 1'b0, 1'b0);

    do_run(20, 0, 0, 32'h0000_0040);
    do_run(0, 0, 0, '0);
    do_run(int'(MAX_CYCLES), 0, 0, '0);
    do_run(0, 0, 7, '0);
    do_run($urandom_range(1, 49), 0, 0, '0);
    do_run(0, 6, 0, '0);
    for (int r = 0; r < 6; r++) begin
      do_run($urandom_range(1, 70), 0, 0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
